// File: rtl/memory_access.sv
// ---------------------------------------------------------------------------
// memory_access -- MEM pipeline stage
//
// Takes the ex->mem pipeline registers and drives the data-memory bus with a
// req/ack handshake whose latency is not known in advance. A load or store
// stalls the pipeline until one of three things happens:
//   - the memory acks the request,
//   - the wait counter reaches TIMEOUT (the stage reports a bus error), or
//   - the address is misaligned (no request is issued and an address error
//     is reported).
// Results reach writeback through registered mem->wb outputs.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   *_mem               ex->mem pipeline registers (held stable while stall=1)
//   stall               holds the ex->mem registers and all earlier stages
//   dmem_req/we/addr/wdata, dmem_rdata/ack
//                       data-memory bus; dmem_ack is a one-cycle strobe
//   reg_d_*_wb          registered writeback controls and write data
//   addr_err_wb         one-cycle pulse: the access was misaligned
//   bus_err_wb          one-cycle pulse: the bus timed out
// ---------------------------------------------------------------------------
module memory_access #(
  parameter int TIMEOUT = 255  // most WAIT cycles without an ack before abort (1..255)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] alu_data_mem,
  input  logic        mem_we_mem,
  input  logic        reg_d_we_mem,
  input  logic [4:0]  reg_d_addr_mem,
  input  logic        reg_d_data_sel_mem,
  input  logic [31:0] reg_t_data_mem,
  output logic        stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        reg_d_we_wb,
  output logic [4:0]  reg_d_addr_wb,
  output logic [31:0] reg_d_data_wb,
  output logic        addr_err_wb,
  output logic        bus_err_wb
);

  typedef enum logic {IDLE, WAIT} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state, state_nxt;
  logic [7:0] cnt;

  logic access, misaligned, aligned_acc, is_load, timeout_hit, complete;

  // A store wins when both the store and the load decode are set.
  assign access      = mem_we_mem | (reg_d_data_sel_mem & reg_d_we_mem);
  assign misaligned  = access & (alu_data_mem[1:0] != 2'b00);
  assign aligned_acc = access & ~misaligned;
  assign is_load     = ~mem_we_mem & reg_d_data_sel_mem & reg_d_we_mem;

  // The timeout is judged in the same cycle as the ack, so an ack that lands
  // on the last allowed cycle still completes the access.
  assign timeout_hit = (state == WAIT) & ~dmem_ack & (cnt == TMO);
  assign complete    = dmem_req & dmem_ack;

  // The bus sees the current instruction directly. The memory only looks at
  // these fields while dmem_req is high.
  assign dmem_we    = mem_we_mem;
  assign dmem_addr  = {alu_data_mem[31:2], 2'b00};
  assign dmem_wdata = reg_t_data_mem;

  // State register and wait counter
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      if (state_nxt == WAIT)
        cnt <= (state == IDLE) ? 8'd1 : cnt + 8'd1;
      else
        cnt <= 8'd0;
    end
  end

  // Next-state logic
  // NOTE: every signal driven from always_comb gets a default first, so no
  // path can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (aligned_acc && !dmem_ack) state_nxt = WAIT;
      WAIT: if (dmem_ack || timeout_hit)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. Reset forces the handshake low, so an abandoned request never
  // stays visible on the bus.
  always_comb begin
    dmem_req = 1'b0;
    stall    = 1'b0;
    if (!rst) begin
      case (state)
        IDLE: begin
          dmem_req = aligned_acc;
          stall    = aligned_acc & ~dmem_ack;
        end
        WAIT: begin
          dmem_req = 1'b1;
          stall    = ~dmem_ack & (cnt != TMO);
        end
        default: ;
      endcase
    end
  end

  // mem->wb registers. The default is a bubble (we=0, no error). Address and
  // data follow the pipeline either way, so a bubble is harmless in WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      reg_d_we_wb   <= 1'b0;
      reg_d_addr_wb <= 5'd0;
      reg_d_data_wb <= 32'd0;
      addr_err_wb   <= 1'b0;
      bus_err_wb    <= 1'b0;
    end else begin
      reg_d_we_wb   <= 1'b0;
      reg_d_addr_wb <= reg_d_addr_mem;
      reg_d_data_wb <= alu_data_mem;
      addr_err_wb   <= 1'b0;
      bus_err_wb    <= 1'b0;
      if (complete) begin
        reg_d_we_wb <= is_load;
        if (is_load) reg_d_data_wb <= dmem_rdata;
      end else if (state == IDLE && !access) begin
        reg_d_we_wb <= reg_d_we_mem;
      end else if (state == IDLE && misaligned) begin
        addr_err_wb <= 1'b1;
      end else if (timeout_hit) begin
        bus_err_wb  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;

  logic        clk;
  logic        rst;
  logic [31:0] alu_data_mem;
  logic        mem_we_mem;
  logic        reg_d_we_mem;
  logic [4:0]  reg_d_addr_mem;
  logic        reg_d_data_sel_mem;
  logic [31:0] reg_t_data_mem;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        reg_d_we_wb;
  logic [4:0]  reg_d_addr_wb;
  logic [31:0] reg_d_data_wb;
  logic        addr_err_wb;
  logic        bus_err_wb;

  memory_access #(.TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .alu_data_mem(alu_data_mem), .mem_we_mem(mem_we_mem),
    .reg_d_we_mem(reg_d_we_mem), .reg_d_addr_mem(reg_d_addr_mem),
    .reg_d_data_sel_mem(reg_d_data_sel_mem), .reg_t_data_mem(reg_t_data_mem),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .reg_d_we_wb(reg_d_we_wb), .reg_d_addr_wb(reg_d_addr_wb),
    .reg_d_data_wb(reg_d_data_wb), .addr_err_wb(addr_err_wb),
    .bus_err_wb(bus_err_wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle of stimulus plus what must be seen: combinational bus/stall in
  // that cycle, and registered WB outputs after the following edge.
  typedef struct {
    logic        rst;
    logic [31:0] alu;
    logic        mem_we;
    logic        rd_we;
    logic [4:0]  rd;
    logic        sel;
    logic [31:0] tdata;
    logic [31:0] rdata;
    logic        ack;
    logic        e_stall;
    logic        e_req;
    logic        e_dwe;
    logic        e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic        e_aerr;
    logic        e_berr;
    logic        e_full;   // also compare WB address and data
  } vec_t;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        aerr;
    logic        berr;
    logic        full;
  } wb_t;

  wb_t   sb[$];
  int    errors = 0;
  int    checks = 0;
  string tag;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s/%s: got 0x%08h expected 0x%08h", tag, name, act, exp);
    end
  endtask

  task automatic cyc(input vec_t v);
    wb_t e;
    wb_t got;
    @(negedge clk);
    rst                = v.rst;
    alu_data_mem       = v.alu;
    mem_we_mem         = v.mem_we;
    reg_d_we_mem       = v.rd_we;
    reg_d_addr_mem     = v.rd;
    reg_d_data_sel_mem = v.sel;
    reg_t_data_mem     = v.tdata;
    dmem_rdata         = v.rdata;
    dmem_ack           = v.ack;
    e = '{v.e_we, v.e_addr, v.e_data, v.e_aerr, v.e_berr, v.e_full};
    sb.push_back(e);
    #1;
    check("stall", 32'(stall), 32'(v.e_stall));
    check("dmem_req", 32'(dmem_req), 32'(v.e_req));
    if (v.e_req) begin
      check("dmem_we", 32'(dmem_we), 32'(v.e_dwe));
      check("dmem_addr", dmem_addr, v.alu & 32'hFFFF_FFFC);
      if (v.e_dwe) check("dmem_wdata", dmem_wdata, v.tdata);
    end
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s/scoreboard: got empty queue expected an entry", tag);
    end else begin
      got = sb.pop_front();
      check("we_wb", 32'(reg_d_we_wb), 32'(got.we));
      check("addr_err_wb", 32'(addr_err_wb), 32'(got.aerr));
      check("bus_err_wb", 32'(bus_err_wb), 32'(got.berr));
      if (got.full) begin
        check("addr_wb", 32'(reg_d_addr_wb), 32'(got.addr));
        check("data_wb", reg_d_data_wb, got.data);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t tbl[11];
    vec_t v;

    rst = 1'b1;
    alu_data_mem = '0; mem_we_mem = 1'b0; reg_d_we_mem = 1'b0;
    reg_d_addr_mem = '0; reg_d_data_sel_mem = 1'b0; reg_t_data_mem = '0;
    dmem_rdata = '0; dmem_ack = 1'b0;

    //          rst alu            mw we rd sel tdata         rdata         ack  stl req dwe  we ad data           ae be full
    tbl[0]  = '{1, 32'h0,        0, 0, 0, 0, 32'h0,        32'h0,        0,   0, 0, 0,   0, 0, 32'h0,        0, 0, 1};
    tbl[1]  = '{0, 32'h1234,     0, 1, 5, 0, 32'h0,        32'h0,        0,   0, 0, 0,   1, 5, 32'h1234,     0, 0, 1};
    tbl[2]  = '{0, 32'hAAAA,     0, 1, 0, 0, 32'h0,        32'h0,        0,   0, 0, 0,   1, 0, 32'hAAAA,     0, 0, 1};
    tbl[3]  = '{0, 32'h55,       0, 0, 7, 0, 32'h0,        32'h99,       1,   0, 0, 0,   0, 7, 32'h55,       0, 0, 1};
    tbl[4]  = '{0, 32'h200,      1, 0, 0, 0, 32'hCAFEF00D, 32'h0,        1,   0, 1, 1,   0, 0, 32'h0,        0, 0, 0};
    tbl[5]  = '{0, 32'h104,      0, 1, 9, 1, 32'h0,        32'h11223344, 1,   0, 1, 0,   1, 9, 32'h11223344, 0, 0, 1};
    tbl[6]  = '{0, 32'h102,      0, 1, 3, 1, 32'h0,        32'h0,        0,   0, 0, 0,   0, 0, 32'h0,        1, 0, 0};
    tbl[7]  = '{0, 32'h201,      1, 0, 0, 0, 32'h1,        32'h0,        1,   0, 0, 0,   0, 0, 32'h0,        1, 0, 0};
    tbl[8]  = '{0, 32'h8,        0, 1, 2, 0, 32'h0,        32'h0,        0,   0, 0, 0,   1, 2, 32'h8,        0, 0, 1};
    tbl[9]  = '{0, 32'h300,      1, 1, 4, 1, 32'h77,       32'h88,       1,   0, 1, 1,   0, 0, 32'h0,        0, 0, 0};
    tbl[10] = '{0, 32'hFFFFFFFC, 0, 1, 31,1, 32'h0,        32'h5A5A,     1,   0, 1, 0,   1, 31,32'h5A5A,     0, 0, 1};

    for (int i = 0; i < 11; i++) begin
      tag = $sformatf("vec%0d", i);
      cyc(tbl[i]);
    end

    // Load 0x100, acked on the fourth request cycle: three stall cycles.
    tag = "load_wait";
    v = '{0, 32'h100, 0, 1, 6, 1, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0};
    for (int i = 0; i < 3; i++) cyc(v);
    v = '{0, 32'h100, 0, 1, 6, 1, 32'h0, 32'hDEADBEEF, 1, 0, 1, 0, 1, 6, 32'hDEADBEEF, 0, 0, 1};
    cyc(v);

    // Store with no ack: request held through cnt==TIMEOUT, then bus error.
    tag = "timeout";
    v = '{0, 32'h40, 1, 0, 0, 0, 32'h1357, 32'h0, 0, 1, 1, 1, 0, 0, 32'h0, 0, 0, 0};
    for (int i = 0; i < 4; i++) cyc(v);
    v = '{0, 32'h40, 1, 0, 0, 0, 32'h1357, 32'h0, 0, 0, 1, 1, 0, 0, 32'h0, 0, 1, 0};
    cyc(v);
    tag = "late_ack";
    v = '{0, 32'h10, 0, 1, 1, 0, 32'h0, 32'hBAD, 1, 0, 0, 0, 1, 1, 32'h10, 0, 0, 1};
    cyc(v);

    // Reset while WAITing: handshake drops at once, WB cleared, ack ignored.
    tag = "rst_wait";
    v = '{0, 32'h80, 0, 1, 8, 1, 32'h0, 32'h0, 0, 1, 1, 0, 0, 0, 32'h0, 0, 0, 0};
    cyc(v);
    cyc(v);
    v = '{1, 32'h80, 0, 1, 8, 1, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 1};
    cyc(v);
    tag = "post_rst";
    v = '{0, 32'h20, 0, 1, 12, 0, 32'h0, 32'hBAD, 1, 0, 0, 0, 1, 12, 32'h20, 0, 0, 1};
    cyc(v);
    v = '{0, 32'h84, 0, 1, 13, 1, 32'h0, 32'h600D, 1, 0, 1, 0, 1, 13, 32'h600D, 0, 0, 1};
    cyc(v);

    tag = "end";
    check("sb_left", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
